// File: rtl/fetch_pkg.sv
// Shared definitions for the RV32I fetch stage: datapath width, NOP encoding,
// FSM state encodings and the sequential-PC helper.
package fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_TRAP  = 2'd3
   } state_t;

   function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry {inst, pc} skid register that parks a memory response while
// decode is stalled. Flush wins over load.
module fetch_buffer
   import fetch_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            load_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] inst_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            valid_o,
   output logic [XLEN-1:0] inst_o,
   output logic [XLEN-1:0] pc_o
);

   logic            valid_q;
   logic [XLEN-1:0] inst_q;
   logic [XLEN-1:0] pc_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         inst_q  <= '0;
         pc_q    <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         inst_q  <= inst_i;
         pc_q    <= pc_i;
      end
   end

   assign valid_o = valid_q;
   assign inst_o  = inst_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/fetch.sv
// RV32I instruction fetch: owns the PC, issues one word read at a time and
// registers {inst, pc, valid} toward decode, honouring stall and redirect.
module fetch
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic            i_clk,
   input  logic            i_rst,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_ready,
   input  logic            i_imem_valid,
   input  logic [XLEN-1:0] i_imem_data,
   input  logic            i_stall,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic [XLEN-1:0] or_inst,
   output logic [XLEN-1:0] or_pc,
   output logic            or_valid,
   output logic            or_exc_misalign
);

   state_t          state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] inst_q;
   logic [XLEN-1:0] opc_q;
   logic            valid_q;
   logic            exc_q;
   logic            outstanding_q;
   logic            kill_q;

   logic            accept;
   logic            resp;
   logic            pending;
   logic            misaligned;
   logic            buf_load;
   logic            buf_flush;
   logic            buf_valid;
   logic [XLEN-1:0] buf_inst;
   logic [XLEN-1:0] buf_pc;

   assign o_imem_req  = (state_q == S_FETCH);
   assign o_imem_addr = {pc_q[XLEN-1:2], 2'b00};
   assign accept      = o_imem_req & i_imem_ready;
   // Responses with nothing in flight are stray and ignored.
   assign resp        = i_imem_valid & outstanding_q;
   assign pending     = (outstanding_q & ~resp) | accept;
   assign misaligned  = |i_redirect_pc[1:0];

   assign buf_load  = ~i_redirect & (state_q == S_WAIT) & resp & ~kill_q & i_stall;
   assign buf_flush = i_redirect | ((state_q == S_HOLD) & ~i_stall);

   fetch_buffer u_buf (
      .clk_i   (i_clk),
      .rst_i   (i_rst),
      .load_i  (buf_load),
      .flush_i (buf_flush),
      .inst_i  (i_imem_data),
      .pc_i    (pc_q),
      .valid_o (buf_valid),
      .inst_o  (buf_inst),
      .pc_o    (buf_pc)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= S_FETCH;
         pc_q          <= RESET_PC;
         inst_q        <= NOP_INST;
         opc_q         <= '0;
         valid_q       <= 1'b0;
         exc_q         <= 1'b0;
         outstanding_q <= 1'b0;
         kill_q        <= 1'b0;
      end else if (i_redirect) begin
         // A request still in flight (or accepted right now) must be drained and dropped.
         pc_q          <= i_redirect_pc;
         inst_q        <= NOP_INST;
         valid_q       <= 1'b0;
         exc_q         <= 1'b0;
         outstanding_q <= pending;
         kill_q        <= pending;
         if (misaligned) begin
            state_q <= S_TRAP;
            opc_q   <= i_redirect_pc;
            exc_q   <= 1'b1;
            valid_q <= 1'b1;
         end else begin
            state_q <= pending ? S_WAIT : S_FETCH;
         end
      end else begin
         if (!i_stall && state_q != S_TRAP) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
         end
         case (state_q)
            S_FETCH: begin
               if (accept) begin
                  state_q       <= S_WAIT;
                  outstanding_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (resp) begin
                  outstanding_q <= 1'b0;
                  kill_q        <= 1'b0;
                  if (kill_q) begin
                     state_q <= S_FETCH;
                  end else if (!i_stall) begin
                     inst_q  <= i_imem_data;
                     opc_q   <= pc_q;
                     valid_q <= 1'b1;
                     pc_q    <= pc_inc(pc_q);
                     state_q <= S_FETCH;
                  end else begin
                     state_q <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!i_stall && buf_valid) begin
                  inst_q  <= buf_inst;
                  opc_q   <= buf_pc;
                  valid_q <= 1'b1;
                  pc_q    <= pc_inc(pc_q);
                  state_q <= S_FETCH;
               end
            end
            S_TRAP: begin
               // The exception stays presented; only a stale killed response is drained.
               if (resp) begin
                  outstanding_q <= 1'b0;
                  kill_q        <= 1'b0;
               end
            end
            default: state_q <= S_FETCH;
         endcase
      end
   end

   assign or_inst         = inst_q;
   assign or_pc           = opc_q;
   assign or_valid        = valid_q;
   assign or_exc_misalign = exc_q;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: behavioural instruction memory with a
// programmable latency feeds a scoreboard that is drained as decode consumes.
module tb_fetch;
   import fetch_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ready = 1'b0;
   logic        i_imem_valid = 1'b0;
   logic [31:0] i_imem_data = 32'h0;
   logic        i_stall = 1'b0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = 32'h0;
   logic [31:0] or_inst;
   logic [31:0] or_pc;
   logic        or_valid;
   logic        or_exc_misalign;

   always #5 clk = ~clk;

   fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
      .i_clk           (clk),
      .i_rst           (i_rst),
      .o_imem_req      (o_imem_req),
      .o_imem_addr     (o_imem_addr),
      .i_imem_ready    (i_imem_ready),
      .i_imem_valid    (i_imem_valid),
      .i_imem_data     (i_imem_data),
      .i_stall         (i_stall),
      .i_redirect      (i_redirect),
      .i_redirect_pc   (i_redirect_pc),
      .or_inst         (or_inst),
      .or_pc           (or_pc),
      .or_valid        (or_valid),
      .or_exc_misalign (or_exc_misalign)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          lat = 1;
   logic        ready_gate = 1'b1;
   logic        m_busy = 1'b0;
   int          m_cnt = 0;
   logic [31:0] m_addr = 32'h0;
   logic        prev_hold = 1'b0;
   logic        prev_redir = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   logic        in_trap = 1'b0;
   int          trap_reqs = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return a ^ 32'h1357_0013;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Monitor, scoreboard and memory model share one block so ordering is fixed.
   always @(negedge clk) begin
      exp_t e;
      if (i_rst) begin
         sb_q.delete();
         m_busy       = 1'b0;
         i_imem_valid = 1'b0;
         i_imem_ready = 1'b0;
         prev_hold    = 1'b0;
      end else begin
         if (or_valid && !or_exc_misalign && !i_stall) begin
            check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check_eq("sb_pc", or_pc, e.pc);
               check_eq("sb_inst", or_inst, e.inst);
               $display("txn pc=%08h inst=%08h", or_pc, or_inst);
            end
         end
         if (!or_valid) check_eq("nop_when_invalid", or_inst, NOP);
         check_eq("addr_align", {30'h0, o_imem_addr[1:0]}, 32'h0);
         if (prev_hold && !prev_redir) begin
            check_eq("req_held", {31'h0, o_imem_req}, 32'h1);
            check_eq("addr_stable", o_imem_addr, prev_addr);
         end
         if (in_trap && o_imem_req) trap_reqs++;
         if (i_redirect) sb_q.delete();
         i_imem_valid = 1'b0;
         if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
               i_imem_valid = 1'b1;
               i_imem_data  = mem_word(m_addr);
               m_busy       = 1'b0;
            end
         end
         i_imem_ready = !m_busy && ready_gate;
         if (o_imem_req && i_imem_ready) begin
            m_busy = 1'b1;
            m_cnt  = lat;
            m_addr = o_imem_addr;
            if (!i_redirect) begin
               e.pc   = o_imem_addr;
               e.inst = mem_word(o_imem_addr);
               sb_q.push_back(e);
            end
         end
         prev_hold  = o_imem_req && !i_imem_ready;
         prev_addr  = o_imem_addr;
         prev_redir = i_redirect;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req_addr(input logic [31:0] a, input string tag);
      int n = 0;
      while (!(o_imem_req && o_imem_addr == a) && n < 50) begin
         tick();
         n++;
      end
      check_eq(tag, 32'(o_imem_req && o_imem_addr == a), 32'd1);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!or_valid && n < 50) begin
         tick();
         n++;
      end
      check_eq(tag, {31'h0, or_valid}, 32'd1);
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_valid"}, {31'h0, or_valid}, 32'd0);
      check_eq({tag, "_inst"}, or_inst, NOP);
      check_eq({tag, "_pc"}, or_pc, 32'h0);
      check_eq({tag, "_exc"}, {31'h0, or_exc_misalign}, 32'd0);
      check_eq({tag, "_req"}, {31'h0, o_imem_req}, 32'd1);
      check_eq({tag, "_addr"}, o_imem_addr, 32'h0);
   endtask

   initial begin
      int n;
      // Reset and first zero-wait fetch
      tick();
      tick();
      check_reset("rst");
      i_rst = 1'b0;
      tick();
      tick();
      check_eq("t1_valid", {31'h0, or_valid}, 32'd1);
      check_eq("t1_inst", or_inst, 32'h0050_0093);
      check_eq("t1_pc", or_pc, 32'h0);
      check_eq("t1_next_addr", o_imem_addr, 32'h4);

      // Stall across the response for 0x8
      wait_req_addr(32'h8, "t2_req8");
      lat = 3;
      tick();
      i_stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check_eq("t2_no_req", {31'h0, o_imem_req}, 32'd0);
         check_eq("t2_frozen_valid", {31'h0, or_valid}, 32'd0);
         check_eq("t2_frozen_pc", or_pc, 32'h4);
         tick();
      end
      i_stall = 1'b0;
      lat = 1;
      tick();
      check_eq("t2_valid", {31'h0, or_valid}, 32'd1);
      check_eq("t2_pc", or_pc, 32'h8);
      check_eq("t2_next_addr", o_imem_addr, 32'hC);

      // Redirect while 0x10 is outstanding
      wait_req_addr(32'h10, "t3_req10");
      lat = 3;
      tick();
      i_redirect = 1'b1;
      i_redirect_pc = 32'h100;
      tick();
      i_redirect = 1'b0;
      n = 0;
      while (!o_imem_req && n < 20) begin
         check_eq("t3_valid_low", {31'h0, or_valid}, 32'd0);
         tick();
         n++;
      end
      lat = 1;
      check_eq("t3_req_delay", n, 2);
      check_eq("t3_addr", o_imem_addr, 32'h100);
      wait_valid("t3_wait");
      check_eq("t3_pc", or_pc, 32'h100);

      // Misaligned redirect traps until the next redirect
      i_redirect = 1'b1;
      i_redirect_pc = 32'h102;
      tick();
      i_redirect = 1'b0;
      check_eq("t4_exc", {31'h0, or_exc_misalign}, 32'd1);
      check_eq("t4_pc", or_pc, 32'h102);
      check_eq("t4_valid", {31'h0, or_valid}, 32'd1);
      check_eq("t4_inst", or_inst, NOP);
      in_trap = 1'b1;
      repeat (6) tick();
      in_trap = 1'b0;
      check_eq("t4_no_req", trap_reqs, 0);
      i_redirect = 1'b1;
      i_redirect_pc = 32'h200;
      tick();
      i_redirect = 1'b0;
      check_eq("t4_exc_clr", {31'h0, or_exc_misalign}, 32'd0);
      wait_req_addr(32'h200, "t4_req200");

      // PC wrap at the top of the address space
      i_redirect = 1'b1;
      i_redirect_pc = 32'hFFFF_FFFC;
      tick();
      i_redirect = 1'b0;
      wait_valid("t5_wait");
      check_eq("t5_pc", or_pc, 32'hFFFF_FFFC);
      check_eq("t5_wrap_addr", o_imem_addr, 32'h0);

      // Memory back-pressure: request must be held
      ready_gate = 1'b0;
      repeat (3) tick();
      check_eq("bp_req", {31'h0, o_imem_req}, 32'd1);
      check_eq("bp_addr", o_imem_addr, 32'h0);
      ready_gate = 1'b1;
      wait_valid("bp_wait");
      check_eq("bp_pc", or_pc, 32'h0);

      // Reset in S_WAIT, then in S_HOLD
      wait_req_addr(32'h8, "t6_req8");
      lat = 4;
      tick();
      i_rst = 1'b1;
      tick();
      check_reset("t6_wait_rst");
      i_rst = 1'b0;
      lat = 1;
      i_stall = 1'b1;
      tick();
      tick();
      check_eq("t6_hold_no_req", {31'h0, o_imem_req}, 32'd0);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      i_stall = 1'b0;
      check_reset("t6_hold_rst");
      wait_valid("t6_wait");
      check_eq("t6_first_pc", or_pc, 32'h0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
